// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / hazard unit.
// Stage records hold indices at REG_AW_MAX width; narrower register files zero-extend into them.
package fwd_pkg;

  localparam int unsigned REG_AW_DEF = 5;
  localparam int unsigned REG_AW_MAX = 8;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef logic [REG_AW_MAX-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t rs;
    reg_idx_t rt;
    reg_idx_t rd;
    logic     regwrite;
    logic     memread;
    logic     valid;
  } ex_rec_t;

  typedef struct packed {
    reg_idx_t rd;
    logic     regwrite;
    logic     valid;
  } pipe_rec_t;

  // A later stage can supply idx only if it really writes a nonzero register equal to idx.
  function automatic logic writes_reg(input pipe_rec_t rec, input reg_idx_t idx);
    return rec.valid && rec.regwrite && (rec.rd != {REG_AW_MAX{1'b0}}) && (rec.rd == idx);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Operand forwarding select for one ALU source of the EX instruction.
module fwd_match
  import fwd_pkg::*;
(
  input  logic      i_ex_valid,
  input  reg_idx_t  i_src,
  input  pipe_rec_t i_mem,
  input  pipe_rec_t i_wb,
  output logic [1:0] o_sel
);

  // EX/MEM result is younger, so it wins over MEM/WB.
  always_comb begin
    o_sel = FWD_RF;
    if (i_ex_valid && writes_reg(i_mem, i_src)) begin
      o_sel = FWD_EXMEM;
    end else if (i_ex_valid && writes_reg(i_wb, i_src)) begin
      o_sel = FWD_MEMWB;
    end else begin
      o_sel = FWD_RF;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX/MEM/WB tracking with operand forwarding selects and optional load-use stall.
// Load-use detection and the stall counter exist only when FWD_LOAD_STALL_EN is defined.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              dec_valid,
  input  logic [REG_AW-1:0] dec_rs,
  input  logic [REG_AW-1:0] dec_rt,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic              dec_regwrite,
  input  logic              dec_memread,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  ex_rec_t   r_ex;
  pipe_rec_t r_mem;
  pipe_rec_t r_wb;
  ex_rec_t   w_ex_next;
  logic      w_stall;

  // Next EX contents: decoded instruction, or a bubble on stall/flush/no-op.
  always_comb begin
    w_ex_next = '0;
    if (dec_valid && !w_stall && !flush) begin
      w_ex_next.rs       = reg_idx_t'(dec_rs);
      w_ex_next.rt       = reg_idx_t'(dec_rt);
      w_ex_next.rd       = reg_idx_t'(dec_rd);
      w_ex_next.regwrite = dec_regwrite;
      w_ex_next.memread  = dec_memread;
      w_ex_next.valid    = 1'b1;
    end else begin
      w_ex_next = '0;
    end
  end

  // Stage records; a flushed EX instruction moves on to MEM marked invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_ex           <= w_ex_next;
      r_mem.rd       <= r_ex.rd;
      r_mem.regwrite <= r_ex.regwrite;
      r_mem.valid    <= r_ex.valid && !flush;
      r_wb           <= r_mem;
    end
  end

  fwd_match u_match_a (
    .i_ex_valid (r_ex.valid),
    .i_src      (r_ex.rs),
    .i_mem      (r_mem),
    .i_wb       (r_wb),
    .o_sel      (fwd_a)
  );

  fwd_match u_match_b (
    .i_ex_valid (r_ex.valid),
    .i_src      (r_ex.rt),
    .i_mem      (r_mem),
    .i_wb       (r_wb),
    .o_sel      (fwd_b)
  );

`ifdef FWD_LOAD_STALL_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Load in EX feeding the decode instruction needs one bubble; flush squashes both anyway.
  always_comb begin
    w_stall = 1'b0;
    if (dec_valid && !flush && r_ex.valid && r_ex.memread &&
        (r_ex.rd != {REG_AW_MAX{1'b0}}) &&
        ((r_ex.rd == reg_idx_t'(dec_rs)) || (r_ex.rd == reg_idx_t'(dec_rt)))) begin
      w_stall = 1'b1;
    end else begin
      w_stall = 1'b0;
    end
  end

  // Saturating count of stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= {CNT_W{1'b0}};
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign stall     = w_stall;
  assign stall_cnt = r_stall_cnt;
`else
  logic w_unused_memread;

  assign w_stall          = 1'b0;
  assign stall            = 1'b0;
  assign stall_cnt        = {CNT_W{1'b0}};
  assign w_unused_memread = r_ex.memread;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit; expectations follow FWD_LOAD_STALL_EN when it is defined.
module tb_fwd_hazard_unit;

  localparam int unsigned AW = 5;
  localparam int unsigned CW = 3;
`ifdef FWD_LOAD_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          dec_valid = 1'b0;
  logic [AW-1:0] dec_rs = '0;
  logic [AW-1:0] dec_rt = '0;
  logic [AW-1:0] dec_rd = '0;
  logic          dec_regwrite = 1'b0;
  logic          dec_memread = 1'b0;
  logic [1:0]    fwd_a;
  logic [1:0]    fwd_b;
  logic          stall;
  logic [CW-1:0] stall_cnt;

  int checks_n = 0;
  int fails_n  = 0;
  int exp_cnt  = 0;

  fwd_hazard_unit #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .dec_valid(dec_valid),
    .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_rd(dec_rd),
    .dec_regwrite(dec_regwrite), .dec_memread(dec_memread),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_n++;
    if (got !== exp) begin
      fails_n++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_dec(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic [AW-1:0] rd, input logic rw, input logic mr);
    dec_valid = v; dec_rs = rs; dec_rt = rt; dec_rd = rd;
    dec_regwrite = rw; dec_memread = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic [AW-1:0] rd, input logic rw, input logic mr);
    set_dec(1'b1, rs, rt, rd, rw, mr);
    tick();
  endtask

  task automatic drain();
    set_dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    repeat (3) tick();
  endtask

  // Load to lrd in EX, consumer (crs, crt) in decode; expected stall computed from the rule.
  task automatic load_use(input string tag, input logic [AW-1:0] lrd,
                          input logic [AW-1:0] crs, input logic [AW-1:0] crt);
    logic exp_st;
    exp_st = STALL_EN && (lrd != 5'd0) && ((lrd == crs) || (lrd == crt));
    drain();
    issue(5'd1, 5'd0, lrd, 1'b1, 1'b1);
    set_dec(1'b1, crs, crt, 5'd6, 1'b1, 1'b0);
    #1;
    check_eq({tag, "_stall"}, {31'd0, stall}, {31'd0, exp_st});
    if (exp_st) exp_cnt = (exp_cnt == 7) ? 7 : exp_cnt + 1;
    tick();
    check_eq({tag, "_stall_gone"}, {31'd0, stall}, 32'd0);
    check_eq({tag, "_cnt"}, {29'd0, stall_cnt}, exp_cnt);
    tick();
  endtask

  initial begin
    #3;
    check_eq("rst_fwd_a", {30'd0, fwd_a}, 32'd0);
    check_eq("rst_fwd_b", {30'd0, fwd_b}, 32'd0);
    check_eq("rst_stall", {31'd0, stall}, 32'd0);
    check_eq("rst_cnt", {29'd0, stall_cnt}, 32'd0);
    #9 rst_n = 1'b1;
    tick();

    // add $3 ; consumer with rs=$3
    issue(5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    issue(5'd3, 5'd4, 5'd5, 1'b1, 1'b0);
    check_eq("exmem_a", {30'd0, fwd_a}, 32'd2);
    check_eq("exmem_b", {30'd0, fwd_b}, 32'd0);
    drain();

    // add $3 ; nop ; sub with rt=$3
    issue(5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    set_dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    issue(5'd1, 5'd3, 5'd6, 1'b1, 1'b0);
    check_eq("memwb_b", {30'd0, fwd_b}, 32'd1);
    check_eq("memwb_a", {30'd0, fwd_a}, 32'd0);
    drain();

    // add $3 ; add $3 ; consumer of $3
    issue(5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    issue(5'd7, 5'd8, 5'd3, 1'b1, 1'b0);
    issue(5'd3, 5'd9, 5'd10, 1'b1, 1'b0);
    check_eq("prio_a", {30'd0, fwd_a}, 32'd2);
    check_eq("prio_b", {30'd0, fwd_b}, 32'd0);
    drain();

    // add $3 ; add $4 ; consumer rs=$4 rt=$3
    issue(5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    issue(5'd1, 5'd2, 5'd4, 1'b1, 1'b0);
    issue(5'd4, 5'd3, 5'd11, 1'b1, 1'b0);
    check_eq("mix_a", {30'd0, fwd_a}, 32'd2);
    check_eq("mix_b", {30'd0, fwd_b}, 32'd1);
    drain();

    // writer to $0 ; consumer of $0
    issue(5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
    issue(5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
    check_eq("r0_a", {30'd0, fwd_a}, 32'd0);
    check_eq("r0_b", {30'd0, fwd_b}, 32'd0);
    drain();

    // non-writing $3 ; consumer of $3
    issue(5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    issue(5'd3, 5'd3, 5'd7, 1'b1, 1'b0);
    check_eq("nowr_a", {30'd0, fwd_a}, 32'd0);
    check_eq("nowr_b", {30'd0, fwd_b}, 32'd0);
    drain();

    // lw $5 ; add using $5
    issue(5'd1, 5'd0, 5'd5, 1'b1, 1'b1);
    set_dec(1'b1, 5'd5, 5'd2, 5'd6, 1'b1, 1'b0);
    #1;
    check_eq("lu_stall", {31'd0, stall}, {31'd0, STALL_EN});
    check_eq("lu_cnt0", {29'd0, stall_cnt}, 32'd0);
    tick();
    if (STALL_EN) exp_cnt = 1;
    check_eq("lu_cnt1", {29'd0, stall_cnt}, exp_cnt);
    check_eq("lu_one_bubble", {31'd0, stall}, 32'd0);
    check_eq("lu_bubble_a", {30'd0, fwd_a}, STALL_EN ? 32'd0 : 32'd2);
    tick();
    check_eq("lu_fwd_a", {30'd0, fwd_a}, 32'd1);
    check_eq("lu_fwd_b", {30'd0, fwd_b}, 32'd0);
    check_eq("lu_no_restall", {31'd0, stall}, 32'd0);

    load_use("lu_rt", 5'd5, 5'd1, 5'd5);
    load_use("lu_r0", 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 6; i++) load_use("lu_sat", 5'd9, 5'd9, 5'd2);
    check_eq("cnt_sat", {29'd0, stall_cnt}, STALL_EN ? 32'd7 : 32'd0);

    // flush with lw in EX and consumer in decode
    drain();
    issue(5'd1, 5'd0, 5'd5, 1'b1, 1'b1);
    set_dec(1'b1, 5'd5, 5'd2, 5'd6, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    check_eq("fl_stall", {31'd0, stall}, 32'd0);
    tick();
    flush = 1'b0;
    tick();
    check_eq("fl_fwd_a", {30'd0, fwd_a}, 32'd0);
    check_eq("fl_cnt", {29'd0, stall_cnt}, exp_cnt);
    drain();

    // reset asserted while a load-use stall is pending
    issue(5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    issue(5'd3, 5'd0, 5'd5, 1'b1, 1'b1);
    set_dec(1'b1, 5'd5, 5'd2, 5'd6, 1'b1, 1'b0);
    #1;
    check_eq("rs_pre_a", {30'd0, fwd_a}, 32'd2);
    check_eq("rs_pre_stall", {31'd0, stall}, {31'd0, STALL_EN});
    #2 rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    check_eq("rs_fwd_a", {30'd0, fwd_a}, 32'd0);
    check_eq("rs_fwd_b", {30'd0, fwd_b}, 32'd0);
    check_eq("rs_stall", {31'd0, stall}, 32'd0);
    check_eq("rs_cnt", {29'd0, stall_cnt}, 32'd0);
    #3 rst_n = 1'b1;
    #1;
    check_eq("rs_post_stall", {31'd0, stall}, 32'd0);
    tick();
    check_eq("rs_post_a", {30'd0, fwd_a}, 32'd0);
    check_eq("rs_post_cnt", {29'd0, stall_cnt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_n, fails_n);
    $finish;
  end

endmodule
